// File: rtl/acc_mul_ctrl.sv
// Shift-and-add multiply sequencer driving the split accumulator and ALU.
// Optional ACC_MUL_BUSY_ERR_EN adds a sticky start_err flag for starts seen while busy.
`timescale 1ns/1ps
module acc_mul_ctrl #(
  parameter int unsigned N_BITS = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       acc_lsb,
  input  logic       alu_carry,
  output logic       bus_rd,
  output logic       acc_in_select,
  output logic [1:0] acc_high_select,
  output logic [1:0] acc_low_select,
  output logic       acc_high_reset_p,
  output logic       fill_value,
  output logic       alu_add_en,
  output logic       rd_en,
  output logic       busy,
`ifdef ACC_MUL_BUSY_ERR_EN
  output logic       start_err,
`endif
  output logic       done
);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_SHR   = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_COPY_L, S_CLR_H, S_EVAL, S_ADD, S_SHIFT, S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_LOAD_H;
      S_LOAD_H: w_next_state = S_COPY_L;
      S_COPY_L: w_next_state = S_CLR_H;
      S_CLR_H:  w_next_state = S_EVAL;
      S_EVAL:   w_next_state = acc_lsb ? S_ADD : S_SHIFT;
      S_ADD:    w_next_state = S_SHIFT;
      S_SHIFT:  w_next_state = (r_cnt == CNT_LAST) ? S_OUT : S_EVAL;
      S_OUT:    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Iteration counter and the add carry that re-enters as the high-half fill bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_CLR_H: begin
          r_cnt   <= '0;
          r_carry <= 1'b0;
        end
        S_ADD:   r_carry <= alu_carry;
        S_SHIFT: begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_carry <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_rd           = 1'b0;
    acc_in_select    = 1'b0;
    acc_high_select  = SEL_HOLD;
    acc_low_select   = SEL_HOLD;
    acc_high_reset_p = 1'b0;
    fill_value       = 1'b0;
    alu_add_en       = 1'b0;
    rd_en            = 1'b0;
    done             = 1'b0;
    busy             = (r_state != S_IDLE);
    case (r_state)
      S_LOAD_H: begin
        bus_rd          = 1'b1;
        acc_in_select   = 1'b1;
        acc_high_select = SEL_LOAD;
      end
      S_COPY_L: acc_low_select = SEL_LOAD;
      S_CLR_H:  acc_high_reset_p = 1'b1;
      S_ADD: begin
        alu_add_en      = 1'b1;
        acc_high_select = SEL_LOAD;
      end
      S_SHIFT: begin
        acc_high_select = SEL_SHR;
        acc_low_select  = SEL_SHR;
        fill_value      = r_carry;
      end
      S_OUT: begin
        rd_en = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ACC_MUL_BUSY_ERR_EN
  logic r_start_err;

  // Accepted start clears the flag; a start seen while busy sets it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_start_err <= 1'b0;
    else if (start) r_start_err <= (r_state != S_IDLE);
  end

  assign start_err = r_start_err;
`endif

endmodule

// File: tb/tb_acc_mul_ctrl.sv
// Bench for acc_mul_ctrl with an accumulator model and 4-bit adder ALU.
// Expected product/latency go into a scoreboard queue at start and are popped at done.
`timescale 1ns/1ps
module tb_acc_mul_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       acc_lsb, alu_carry;
  logic       bus_rd, acc_in_select, acc_high_reset_p, fill_value;
  logic       alu_add_en, rd_en, busy, done;
  logic [1:0] acc_high_select, acc_low_select;
`ifdef ACC_MUL_BUSY_ERR_EN
  logic       start_err;
`endif

  acc_mul_ctrl #(.N_BITS(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .acc_lsb(acc_lsb), .alu_carry(alu_carry),
    .bus_rd(bus_rd), .acc_in_select(acc_in_select),
    .acc_high_select(acc_high_select), .acc_low_select(acc_low_select),
    .acc_high_reset_p(acc_high_reset_p), .fill_value(fill_value),
    .alu_add_en(alu_add_en), .rd_en(rd_en), .busy(busy),
`ifdef ACC_MUL_BUSY_ERR_EN
    .start_err(start_err),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Accumulator and ALU model
  logic [3:0] r_high = '0, r_low = '0, r_mcand = '0, r_mplier = '0;
  logic [4:0] w_sum;
  assign w_sum     = {1'b0, r_high} + {1'b0, r_mcand};
  assign alu_carry = w_sum[4];
  assign acc_lsb   = r_low[0];

  always @(posedge clk) begin
    if (acc_high_reset_p) r_high <= '0;
    else case (acc_high_select)
      2'b01: r_high <= {fill_value, r_high[3:1]};
      2'b10: r_high <= {r_high[2:0], 1'b0};
      2'b11: r_high <= acc_in_select ? r_mplier : w_sum[3:0];
      default: ;
    endcase
    case (acc_low_select)
      2'b01: r_low <= {r_high[0], r_low[3:1]};
      2'b10: r_low <= {r_low[2:0], 1'b0};
      2'b11: r_low <= r_high;
      default: ;
    endcase
  end

  logic [11:0] w_outs;
  assign w_outs = {bus_rd, acc_in_select, acc_high_select, acc_low_select,
                   acc_high_reset_p, fill_value, alu_add_en, rd_en, busy, done};

  typedef struct {
    logic [7:0] prod;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] mcand, input logic [3:0] mplier);
    r_mcand  = mcand;
    r_mplier = mplier;
  endtask

  task automatic push_op(input logic [3:0] mcand, input logic [3:0] mplier);
    exp_t e;
    set_ops(mcand, mplier);
    e.prod = 8'(mcand) * 8'(mplier);
    e.lat  = 3 + 2 * 4 + $countones(mplier) + 1;
    sb.push_back(e);
  endtask

  // Advance until done or budget; cyc is the cycle index since the start edge.
  task automatic wait_done(input int budget, inout int cyc, output bit saw_add,
                           output bit saw_fill, output int busy_cyc);
    saw_add = 0; saw_fill = 0; busy_cyc = 0;
    forever begin
      if (busy) busy_cyc++;
      if (alu_add_en) saw_add = 1;
      if (acc_high_select == 2'b01 && fill_value) saw_fill = 1;
      if (done || cyc >= budget) break;
      step();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cyc);
    exp_t e;
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.prod = 'x;
      e.lat  = -1;
    end
    check({tag, "_product"}, 32'({r_high, r_low}), 32'(e.prod));
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
  endtask

  initial begin
    int  cyc, busy_cyc, nshift;
    bit  saw_add, saw_fill;

    #2 reset_n = 1'b0;
    #1 check("rst_outs", 32'(w_outs), 32'd0);
`ifdef ACC_MUL_BUSY_ERR_EN
    check("rst_start_err", 32'(start_err), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle20_outs", 32'(w_outs), 32'd0);
    end

    // 13 x 11
    push_op(4'd13, 4'd11);
    start = 1'b1; step(); start = 1'b0;
    cyc = 1;
    wait_done(40, cyc, saw_add, saw_fill, busy_cyc);
    check_result("t1", cyc);
    check("t1_busy_cycles", 32'(busy_cyc), 32'd15);
    check("t1_rd_en", 32'(rd_en), 32'd1);
    step();
    check("t1_idle_after", 32'(w_outs), 32'd0);

    // 15 x 15, carry must re-enter via fill
    push_op(4'd15, 4'd15);
    start = 1'b1; step(); start = 1'b0;
    cyc = 1;
    wait_done(40, cyc, saw_add, saw_fill, busy_cyc);
    check_result("t2", cyc);
    check("t2_saw_fill", 32'(saw_fill), 32'd1);
    step();

    // 9 x 0, no adds
    push_op(4'd9, 4'd0);
    start = 1'b1; step(); start = 1'b0;
    cyc = 1;
    wait_done(40, cyc, saw_add, saw_fill, busy_cyc);
    check_result("t3", cyc);
    check("t3_no_add", 32'(saw_add), 32'd0);
    step();

    // start held high: back-to-back 3 x 5
    push_op(4'd3, 4'd5);
    push_op(4'd3, 4'd5);
    start = 1'b1; step();
    check("t4_load1_bus_rd", 32'(bus_rd), 32'd1);
`ifdef ACC_MUL_BUSY_ERR_EN
    check("t4_err_before", 32'(start_err), 32'd0);
`endif
    step();
`ifdef ACC_MUL_BUSY_ERR_EN
    check("t4_err_set", 32'(start_err), 32'd1);
`endif
    cyc = 2;
    wait_done(40, cyc, saw_add, saw_fill, busy_cyc);
    check_result("t4a", cyc);
    step();
    check("t4_gap_busy", 32'(busy), 32'd0);
    step();
    check("t4_load2_bus_rd", 32'(bus_rd), 32'd1);
`ifdef ACC_MUL_BUSY_ERR_EN
    check("t4_err_cleared", 32'(start_err), 32'd0);
`endif
    start = 1'b0;
    cyc = 1;
    wait_done(40, cyc, saw_add, saw_fill, busy_cyc);
    check_result("t4b", cyc);
    step();

    // reset during the 2nd SHIFT of 13 x 11
    set_ops(4'd13, 4'd11);
    start = 1'b1; step(); start = 1'b0;
    cyc = 1; nshift = 0;
    forever begin
      if (acc_high_select == 2'b01) nshift++;
      if (nshift >= 2 || cyc >= 40) break;
      step();
      cyc++;
    end
    check("t5_reached_shift2", 32'(nshift), 32'd2);
    reset_n = 1'b0;
    #1 check("t5_async_outs", 32'(w_outs), 32'd0);
    step();
    reset_n = 1'b1;
    check("t5_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_quiet_outs", 32'(w_outs), 32'd0);
    end

    // fresh op after the abort
    push_op(4'd7, 4'd6);
    start = 1'b1; step(); start = 1'b0;
    cyc = 1;
    wait_done(40, cyc, saw_add, saw_fill, busy_cyc);
    check_result("t6", cyc);
    step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
